// File: rtl/regfile_writeback_queue.sv
// Write-side front end of the integer register file: merges ALU results (priority) with
// buffered long-latency results, drops x0 writes, and forwards pending values to decode.
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [63:0]   alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [4:0]    lsu_rd,
  input  logic [63:0]   lsu_data,
  output logic          RegWrite,
  output logic [4:0]    rd,
  output logic [63:0]   Write_Data,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          fwd1_hit,
  output logic [63:0]   fwd1_data,
  output logic          fwd2_hit,
  output logic [63:0]   fwd2_data,
  output logic [CW-1:0] queue_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] live_q, live_d;
  logic [4:0]       rd_q   [DEPTH];
  logic [63:0]      data_q [DEPTH];

  logic          write_en_q;
  logic [4:0]    write_rd_q;
  logic [63:0]   write_data_q;

  logic alu_win, enq, pop;

  assign alu_win   = alu_valid && (alu_rd != 5'd0);
  assign lsu_ready = (count_q < CW'(DEPTH));
  assign enq       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
  // The ALU owns the write port whenever it has a real result, so the queue only drains
  // in cycles where the ALU is idle or targets x0.
  assign pop       = !alu_win && (count_q != '0);

  assign RegWrite    = write_en_q;
  assign rd          = write_rd_q;
  assign Write_Data  = write_data_q;
  assign queue_count = count_q;

  // A younger ALU write to the same rd makes older queued results obsolete, including an
  // LSU result accepted alongside it (the LSU result is the older of the two).
  always_comb begin
    live_d = live_q;
    for (int j = 0; j < int'(DEPTH); j++) begin
      if (alu_win && (rd_q[j] == alu_rd)) live_d[j] = 1'b0;
    end
    if (enq) live_d[tail_q] = !(alu_win && (lsu_rd == alu_rd));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      live_q       <= '0;
      write_en_q   <= 1'b0;
      write_rd_q   <= 5'd0;
      write_data_q <= 64'd0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        rd_q[j]   <= 5'd0;
        data_q[j] <= 64'd0;
      end
    end else begin
      live_q  <= live_d;
      count_q <= count_q + CW'(enq) - CW'(pop);
      if (enq) begin
        rd_q[tail_q]   <= lsu_rd;
        data_q[tail_q] <= lsu_data;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) head_q <= head_q + PW'(1);

      if (alu_win) begin
        write_en_q   <= 1'b1;
        write_rd_q   <= alu_rd;
        write_data_q <= alu_data;
      end else if (pop) begin
        write_en_q <= live_q[head_q];
        if (live_q[head_q]) begin
          write_rd_q   <= rd_q[head_q];
          write_data_q <= data_q[head_q];
        end
      end else begin
        write_en_q <= 1'b0;
      end
    end
  end

  // Scans oldest to youngest so the youngest live match wins; the output register is the
  // oldest pending value and only supplies data when no queue entry matches.
  function automatic logic [64:0] lookup(input logic [4:0] rs);
    logic          hit;
    logic [63:0]   data;
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = 64'd0;
    if (rs != 5'd0) begin
      if (write_en_q && (write_rd_q == rs)) begin
        hit  = 1'b1;
        data = write_data_q;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && live_q[idx] && (rd_q[idx] == rs)) begin
          hit  = 1'b1;
          data = data_q[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  always_comb begin
    {fwd1_hit, fwd1_data} = lookup(rs1);
    {fwd2_hit, fwd2_data} = lookup(rs2);
  end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_regfile_writeback_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = 5'd0;
  logic [63:0] alu_data = 64'd0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = 5'd0;
  logic [63:0] lsu_data = 64'd0;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [63:0] Write_Data;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic        fwd1_hit, fwd2_hit;
  logic [63:0] fwd1_data, fwd2_data;
  logic [2:0]  queue_count;

  int passed = 0;
  int total  = 0;

  regfile_writeback_queue #(.DEPTH(4), .CW(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .RegWrite(RegWrite), .rd(rd), .Write_Data(Write_Data),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .queue_count(queue_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] r, input logic [63:0] d);
    alu_valid = v; alu_rd = r; alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] r, input logic [63:0] d);
    lsu_valid = v; lsu_rd = r; lsu_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_regwrite", RegWrite, 0);
    check("rst_rd", rd, 0);
    check("rst_wdata", Write_Data, 0);
    check("rst_count", queue_count, 0);
    check("rst_ready", lsu_ready, 1);
    rs1 = 5'd3; #1;
    check("rst_fwd1_hit", fwd1_hit, 0);
    check("rst_fwd1_data", fwd1_data, 0);
    rs1 = 5'd0;
    reset = 1'b1;
    step();
    check("post_release_regwrite", RegWrite, 0);

    // 1: single ALU write
    set_alu(1, 5'd5, 64'h1234);
    step();
    check("t1_regwrite", RegWrite, 1);
    check("t1_rd", rd, 5);
    check("t1_wdata", Write_Data, 64'h1234);
    set_alu(0, 5'd0, 64'd0);
    step();
    check("t1_idle_regwrite", RegWrite, 0);

    // 2: fill the queue while the ALU holds the port, then drain in order
    set_alu(1, 5'd7, 64'h77);
    for (int k = 1; k <= 4; k++) begin
      set_lsu(1, 5'(k), 64'hA0 + 64'(k));
      step();
      check("t2_alu_regwrite", RegWrite, 1);
      check("t2_alu_rd", rd, 7);
    end
    check("t2_full_count", queue_count, 4);
    check("t2_full_ready", lsu_ready, 0);
    set_alu(0, 5'd0, 64'd0);
    set_lsu(0, 5'd0, 64'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("t2_drain_regwrite", RegWrite, 1);
      check("t2_drain_rd", rd, 5'(k));
      check("t2_drain_data", Write_Data, 64'hA0 + 64'(k));
      check("t2_drain_count", queue_count, 3'(4 - k));
      check("t2_drain_ready", lsu_ready, 1);
    end
    step();
    check("t2_empty_regwrite", RegWrite, 0);

    // 3: two pending writes to x3, youngest forwarded
    set_alu(1, 5'd8, 64'h88);
    set_lsu(1, 5'd3, 64'h11);
    step();
    set_lsu(1, 5'd3, 64'h22);
    step();
    set_lsu(0, 5'd0, 64'd0);
    set_alu(0, 5'd0, 64'd0);
    rs1 = 5'd3; rs2 = 5'd8; #1;
    check("t3_count", queue_count, 2);
    check("t3_fwd1_hit", fwd1_hit, 1);
    check("t3_fwd1_data", fwd1_data, 64'h22);
    check("t3_fwd2_hit_outreg", fwd2_hit, 1);
    check("t3_fwd2_data_outreg", fwd2_data, 64'h88);
    step();
    check("t3_pop1_rd", rd, 3);
    check("t3_pop1_data", Write_Data, 64'h11);
    check("t3_pop1_fwd_data", fwd1_data, 64'h22);
    step();
    check("t3_pop2_data", Write_Data, 64'h22);
    check("t3_pop2_fwd_hit", fwd1_hit, 1);
    check("t3_pop2_fwd_data", fwd1_data, 64'h22);
    step();
    check("t3_drained_fwd_hit", fwd1_hit, 0);
    check("t3_drained_fwd_data", fwd1_data, 0);
    check("t3_drained_fwd2_hit", fwd2_hit, 0);

    // 4: ALU kills an older queued write to x9
    set_lsu(1, 5'd9, 64'h55);
    step();
    set_lsu(0, 5'd0, 64'd0);
    set_alu(1, 5'd9, 64'h66);
    rs1 = 5'd9;
    step();
    set_alu(0, 5'd0, 64'd0);
    #1;
    check("t4_alu_regwrite", RegWrite, 1);
    check("t4_alu_data", Write_Data, 64'h66);
    check("t4_count", queue_count, 1);
    check("t4_fwd_data", fwd1_data, 64'h66);
    step();
    check("t4_dead_regwrite", RegWrite, 0);
    check("t4_dead_hold_rd", rd, 9);
    check("t4_dead_hold_data", Write_Data, 64'h66);
    check("t4_dead_count", queue_count, 0);
    check("t4_dead_fwd_hit", fwd1_hit, 0);

    // 4b: LSU and ALU to the same rd in one cycle; LSU entry enqueued dead
    set_lsu(1, 5'd10, 64'hAA);
    set_alu(1, 5'd10, 64'hBB);
    step();
    set_lsu(0, 5'd0, 64'd0);
    set_alu(0, 5'd0, 64'd0);
    check("t4b_count", queue_count, 1);
    check("t4b_data", Write_Data, 64'hBB);
    step();
    check("t4b_dead_regwrite", RegWrite, 0);
    check("t4b_dead_data", Write_Data, 64'hBB);

    // 5: x0 traffic on both sources
    set_alu(1, 5'd0, 64'hDEAD);
    set_lsu(1, 5'd0, 64'hBEEF);
    rs1 = 5'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_regwrite", RegWrite, 0);
      check("t5_count", queue_count, 0);
      check("t5_ready", lsu_ready, 1);
      check("t5_fwd1_hit", fwd1_hit, 0);
    end
    set_alu(0, 5'd0, 64'd0);
    set_lsu(0, 5'd0, 64'd0);

    // 6: async reset with a partly full queue
    set_alu(1, 5'd8, 64'h99);
    for (int k = 0; k < 3; k++) begin
      set_lsu(1, 5'd11 + 5'(k), 64'hC1 + 64'(k));
      step();
    end
    set_alu(0, 5'd0, 64'd0);
    set_lsu(0, 5'd0, 64'd0);
    check("t6_pre_count", queue_count, 3);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_regwrite", RegWrite, 0);
    check("t6_rst_count", queue_count, 0);
    check("t6_rst_rd", rd, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    rs1 = 5'd11;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_no_stale_regwrite", RegWrite, 0);
      check("t6_no_stale_count", queue_count, 0);
      check("t6_no_stale_fwd", fwd1_hit, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side front end of the 64-bit, 32-entry integer register file in the pipelined RISC-V core.
- Merges two result sources into the register file's single write port (RegWrite/rd/Write_Data):
  - single-cycle ALU results, which have priority;
  - long-latency LSU/MUL results, buffered in a small FIFO.
- Suppresses all x0 writes, because the register file does not hardwire x0.
- Provides forwarding of pending (not yet written) values to the decode-stage read ports.

Parameters:
- DEPTH, 4: number of queue entries for long-latency results (power of two, 2..16).
- CW, 3: width of queue_count; equals log2(DEPTH)+1.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  64  ALU result.
- lsu_valid  in  1  long-latency result offered.
- lsu_ready  out  1  queue can accept a long-latency result this cycle.
- lsu_rd  in  5  long-latency destination register.
- lsu_data  in  64  long-latency result.
- RegWrite  out  1  register file write enable (registered).
- rd  out  5  register file write address (registered).
- Write_Data  out  64  register file write data (registered).
- rs1  in  5  decode read address 1.
- rs2  in  5  decode read address 2.
- fwd1_hit  out  1  rs1 has a pending value here.
- fwd1_data  out  64  pending value for rs1.
- fwd2_hit  out  1  rs2 has a pending value here.
- fwd2_data  out  64  pending value for rs2.
- queue_count  out  CW  occupied queue entries, live and dead.

Behaviour:
- Reset (async, reset=0):
  - RegWrite=0, rd=0, Write_Data=0.
  - Queue empty, queue_count=0, all entries invalid, lsu_ready=1.
  - fwd*_hit=0, fwd*_data=0.
  - Release is synchronous to clock in the RTL; no write port activity until the first edge after release.
  - Reset mid-drain discards all queued entries without writing them.
- Ordering contract: arrival order equals program order. An ALU result accepted in cycle t is younger than every queued entry. When LSU and ALU are both accepted in the same cycle, the LSU result is the older of the two.
- Enqueue:
  - Occurs when lsu_valid && lsu_ready.
  - lsu_rd==0: the handshake completes but nothing is enqueued.
  - lsu_ready = (queue_count < DEPTH). It is a function of registered count only, with no combinational path from inputs.
- ALU kill:
  - An accepted ALU result with alu_rd!=0 marks every live queue entry with rd==alu_rd as dead.
  - This includes an LSU entry enqueued in the same cycle with the same rd, which is enqueued dead.
- Write-port selection, evaluated each cycle and registered at the clock edge:
  1. alu_valid && alu_rd!=0: next RegWrite=1, rd=alu_rd, Write_Data=alu_data. The queue does not pop.
  2. Otherwise, queue non-empty: pop the head.
     - Live head: RegWrite=1 with the head's rd and data.
     - Dead head: RegWrite=0; rd and Write_Data hold their previous values.
  3. Otherwise: RegWrite=0; rd and Write_Data hold.
- Latency:
  - ALU result reaches the write port 1 cycle after acceptance.
  - A queued result reaches the write port ≥1 cycle after enqueue; a new entry is never popped in the cycle it is enqueued.
- Simultaneous pop and enqueue when full: not permitted, because lsu_ready=0 when full. Count decrements by 1.
- Forwarding (combinational from rs1/rs2 and registered state):
  - fwdN_hit=1 iff rsN!=0 and either a live queue entry has rd==rsN, or (RegWrite && rd==rsN).
  - Data priority: youngest matching live queue entry, then the output register.
  - Same-cycle ALU/LSU inputs are not forwarded; the pipeline bypass covers them.
  - When hit=0, fwdN_data=0.
- Pointers wrap modulo DEPTH. queue_count ranges 0..DEPTH.

Test Plan:
1. Reset, then alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle -> next cycle RegWrite=1, rd=5, Write_Data=0x1234; the following cycle RegWrite=0.
2. Enqueue LSU results rd=1..4 (data 0xA1..0xA4) with alu_valid held at 1, rd=7 for 4 cycles -> lsu_ready=0 after the 4th enqueue, queue_count=4, RegWrite shows only rd=7. Then alu_valid=0 -> writes rd=1,2,3,4 in order on consecutive cycles; lsu_ready=1 after the first pop.
3. Queue rd=3 data 0x11, then rd=3 data 0x22 in the next cycle; rs1=3 -> fwd1_hit=1, fwd1_data=0x22. After both drain, fwd1_hit=0.
4. Queue rd=9 data 0x55, then ALU rd=9 data 0x66 -> ALU write issues; the queued entry dies and pops with RegWrite=0; the register file never receives 0x55.
5. alu_rd=0 and lsu_rd=0 with valids high -> RegWrite never asserts, queue_count stays 0, fwd hits with rs1=0 stay 0.
6. Queue 3 entries, assert reset=0 asynchronously between clock edges -> RegWrite=0 and queue_count=0 immediately; after release, no stale writes occur.
